addr_mode_sequencer: RTL

//  Parametrised effective-address (EA) sequencer for the 6502 core; successor to the per-mode address states
//  in the decoder. Given an addressing mode from the decoder, fetches operand and pointer bytes through a
//  req/ack memory port, applies X/Y indexing with page-cross fix-up, and returns a full EA in one pulse.

---
 rtl/addr_mode_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/addr_mode_sequencer.sv
// Effective-address sequencer for the 6502 core: fetches operand/pointer bytes over a
// req/ack read port, applies X/Y indexing with page-cross fix-up, and pulses the final EA.
module addr_mode_sequencer #(
    parameter int ADDR_W       = 16,
    parameter int ZP_WRAP      = 1,
    parameter int PAGE_PENALTY = 1,
    parameter int IND_BUG      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              start,
    input  logic [3:0]        mode,
    input  logic              store_op,
    input  logic [7:0]        index_x,
    input  logic [7:0]        index_y,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              ready,
    output logic              pc_inc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] ea,
    output logic              ea_valid,
    output logic              page_cross,
    output logic              mode_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_LO, S_FETCH_HI, S_INDEX, S_PTR_LO, S_PTR_HI, S_FIXUP, S_DONE, S_ERR
    } state_t;

    localparam logic [3:0] M_IMP   = 4'd0;
    localparam logic [3:0] M_IMM   = 4'd1;
    localparam logic [3:0] M_ZPG   = 4'd2;
    localparam logic [3:0] M_ZPG_X = 4'd3;
    localparam logic [3:0] M_ZPG_Y = 4'd4;
    localparam logic [3:0] M_ABS   = 4'd5;
    localparam logic [3:0] M_ABS_Y = 4'd7;
    localparam logic [3:0] M_IND_X = 4'd8;
    localparam logic [3:0] M_IND_Y = 4'd9;
    localparam logic [3:0] M_IND   = 4'd10;

    state_t      state_q, state_d;
    logic [3:0]  mode_q, mode_d;
    logic        store_q, store_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] base_q, base_d;
    logic [15:0] sum_q, sum_d;
    logic        cross_q, cross_d;
    logic [15:0] ea_q, ea_d;

    logic        fetch_st, xfer, fixup_needed, hi_wrap;
    logic [7:0]  idx;
    logic [8:0]  zp_sum;
    logic [15:0] pc16, abs_word, ptr_word, ptr_hi_addr, result;
    logic        res_cross;

    assign pc16     = pc_in[15:0];
    assign fetch_st = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);
    assign mem_req  = fetch_st || (state_q == S_PTR_LO) || (state_q == S_PTR_HI);
    assign xfer     = mem_req & mem_ack & clk_enable;

    assign idx    = (mode_q == M_ZPG_Y || mode_q == M_ABS_Y || mode_q == M_IND_Y) ? y_q : x_q;
    // lo_q holds the operand low byte in FETCH_HI and the pointer low byte in PTR_HI,
    // so this carry is the page-cross flag in both places.
    assign zp_sum       = {1'b0, lo_q} + {1'b0, idx};
    assign fixup_needed = store_q | ((PAGE_PENALTY != 0) & zp_sum[8]);
    assign abs_word     = {mem_rdata, lo_q};
    assign ptr_word     = {mem_rdata, lo_q};

    assign hi_wrap     = (mode_q == M_IND_X) || (mode_q == M_IND_Y && ZP_WRAP != 0) ||
                         (mode_q == M_IND && IND_BUG != 0);
    assign ptr_hi_addr = hi_wrap ? {base_q[15:8], base_q[7:0] + 8'd1} : base_q + 16'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        mode_d    = mode_q;
        store_d   = store_q;
        x_d       = x_q;
        y_d       = y_q;
        lo_d      = lo_q;
        base_d    = base_q;
        sum_d     = sum_q;
        cross_d   = cross_q;
        ea_d      = ea_q;
        result    = 16'h0000;
        res_cross = 1'b0;

        if (clk_enable) begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    mode_d  = mode;
                    store_d = store_op;
                    x_d     = index_x;
                    y_d     = index_y;
                    if (mode == M_IMP) begin
                        state_d = S_DONE;
                    end else if (mode == M_IMM) begin
                        result  = pc16;
                        state_d = S_DONE;
                    end else if (mode > M_IND) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_FETCH_LO;
                    end
                end
                S_FETCH_LO: if (xfer) begin
                    lo_d = mem_rdata;
                    if (mode_q == M_ZPG) begin
                        result  = {8'h00, mem_rdata};
                        state_d = S_DONE;
                    end else if (mode_q == M_ZPG_X || mode_q == M_ZPG_Y || mode_q == M_IND_X) begin
                        state_d = S_INDEX;
                    end else if (mode_q == M_IND_Y) begin
                        base_d  = {8'h00, mem_rdata};
                        state_d = S_PTR_LO;
                    end else begin
                        state_d = S_FETCH_HI;
                    end
                end
                S_INDEX: begin
                    if (mode_q == M_IND_X) begin
                        base_d  = {8'h00, zp_sum[7:0]};
                        state_d = S_PTR_LO;
                    end else begin
                        result  = (ZP_WRAP != 0) ? {8'h00, zp_sum[7:0]} : {7'h00, zp_sum};
                        state_d = S_DONE;
                    end
                end
                S_FETCH_HI: if (xfer) begin
                    if (mode_q == M_IND) begin
                        base_d  = abs_word;
                        state_d = S_PTR_LO;
                    end else if (mode_q == M_ABS) begin
                        result  = abs_word;
                        state_d = S_DONE;
                    end else begin
                        result    = abs_word + {8'h00, idx};
                        res_cross = zp_sum[8];
                        state_d   = fixup_needed ? S_FIXUP : S_DONE;
                    end
                end
                S_PTR_LO: if (xfer) begin
                    lo_d    = mem_rdata;
                    state_d = S_PTR_HI;
                end
                S_PTR_HI: if (xfer) begin
                    if (mode_q == M_IND_Y) begin
                        result    = ptr_word + {8'h00, idx};
                        res_cross = zp_sum[8];
                        state_d   = fixup_needed ? S_FIXUP : S_DONE;
                    end else begin
                        result  = ptr_word;
                        state_d = S_DONE;
                    end
                end
                S_FIXUP: begin
                    result    = sum_q;
                    res_cross = cross_q;
                    state_d   = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // The visible EA only changes on the edge that enters DONE.
        if (state_d == S_FIXUP && state_q != S_FIXUP) begin
            sum_d   = result;
            cross_d = res_cross;
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            ea_d    = result;
            cross_d = res_cross;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 4'h0;
            store_q <= 1'b0;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            lo_q    <= 8'h00;
            base_q  <= 16'h0000;
            sum_q   <= 16'h0000;
            cross_q <= 1'b0;
            ea_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            store_q <= store_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lo_q    <= lo_d;
            base_q  <= base_d;
            sum_q   <= sum_d;
            cross_q <= cross_d;
            ea_q    <= ea_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign pc_inc     = (fetch_st & mem_ack) | ((state_q == S_DONE) & (mode_q == M_IMM));
    assign mem_addr   = fetch_st                ? pc_in :
                        (state_q == S_PTR_LO)   ? ADDR_W'(base_q) :
                        (state_q == S_PTR_HI)   ? ADDR_W'(ptr_hi_addr) : '0;
    assign ea         = ADDR_W'(ea_q);
    assign ea_valid   = (state_q == S_DONE);
    assign page_cross = (state_q == S_DONE) & cross_q;
    assign mode_err   = (state_q == S_ERR);

endmodule
